// File: rtl/vmem_seq_if.sv
// ----------------------------------------------------------------------------
// vmem_seq_if
//   Single-port data SRAM bus that the vector memory sequencer drives.
//   The scalar MEM stage and the vector sequencer share this SRAM.
//
//   Signals:
//     csb    chip select, active-low          (master -> slave)
//     web    write enable, active-low         (master -> slave)
//     addr   word address, ADDR_W bits        (master -> slave)
//     wdata  write data, DATA_W bits          (master -> slave)
//     rdata  read data, valid one cycle after a read access (slave -> master)
// ----------------------------------------------------------------------------
interface vmem_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              csb;
    logic              web;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;

    modport master (
        output csb,
        output web,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  csb,
        input  web,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/vmem_seq.sv
// ----------------------------------------------------------------------------
// vmem_seq
//   Vector memory sequencer for the MEM stage. Takes one vector load/store
//   from EX/MEM and serialises its LANES lane accesses onto the shared
//   single-port data SRAM, stalling the front of the pipeline meanwhile.
//   When idle, the scalar MEM-stage SRAM request is passed straight through.
//
//   Configuration macro: VMEM_SEQ_STRIDE_EN
//     defined   : lane address = base + k*stride_i
//     undefined : stride fixed at 1, stride_i ignored
//
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     start_i         EX/MEM holds a vector memory instruction
//     is_store_i      1 = store, 0 = load (sampled with start_i)
//     base_addr_i     lane-0 word address (low ADDR_W bits used)
//     stride_i        word stride between lanes
//     vdata_i         store data, lane k = [k*DATA_W +: DATA_W]
//     scal_*_i        scalar SRAM request (active-low csb/web)
//     sram            SRAM bus (vmem_seq_if master)
//     stall_o         freeze PC, IF/ID, ID/EX and EX/MEM
//     busy_o          sequencer not idle
//     vload_data_o    gathered load data
//     vload_valid_o   one-cycle pulse when vload_data_o is complete
// ----------------------------------------------------------------------------
module vmem_seq #(
    parameter int LANES  = 8,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    localparam int K_W   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    is_store_i,
    input  logic [31:0]             base_addr_i,
    input  logic [ADDR_W-1:0]       stride_i,
    input  logic [LANES*DATA_W-1:0] vdata_i,
    input  logic                    scal_csb_i,
    input  logic                    scal_web_i,
    input  logic [ADDR_W-1:0]       scal_addr_i,
    input  logic [DATA_W-1:0]       scal_wdata_i,
    vmem_seq_if.master              sram,
    output logic                    stall_o,
    output logic                    busy_o,
    output logic [LANES*DATA_W-1:0] vload_data_o,
    output logic                    vload_valid_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [K_W-1:0] K_LAST = K_W'(LANES - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic [K_W-1:0]          r_k;
    logic                    r_store;
    logic [ADDR_W-1:0]       r_base;
    logic [LANES*DATA_W-1:0] r_vdata;
    logic [LANES*DATA_W-1:0] r_ld;
    logic                    r_vld;

    logic [ADDR_W-1:0]       w_k_ext;
    logic [ADDR_W-1:0]       w_off;
    logic [ADDR_W-1:0]       w_lane_addr;
    logic                    w_last;
    logic [K_W-1:0]          w_km1;

    logic                    w_csb;
    logic                    w_web;
    logic [ADDR_W-1:0]       w_addr;
    logic [DATA_W-1:0]       w_wdata;
    logic                    w_stall;

    assign w_k_ext = ADDR_W'(r_k);
    assign w_last  = (r_k == K_LAST);
    assign w_km1   = r_k - K_W'(1);

`ifdef VMEM_SEQ_STRIDE_EN
    logic [ADDR_W-1:0] r_stride;
    logic              w_unused;

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start_i) begin
            r_stride <= stride_i;
        end
    end

    // Product truncates to ADDR_W, so addresses wrap modulo 2^ADDR_W.
    assign w_off    = r_stride * w_k_ext;
    assign w_unused = ^base_addr_i[31:ADDR_W];
`else
    logic w_unused;

    assign w_off    = w_k_ext;
    assign w_unused = ^{stride_i, base_addr_i[31:ADDR_W]};
`endif

    assign w_lane_addr = r_base + w_off;

    // Op latch: data only, no reset needed.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start_i) begin
            r_store <= is_store_i;
            r_base  <= base_addr_i[ADDR_W-1:0];
            r_vdata <= vdata_i;
        end
    end

    // Control state, counter and gathered load result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_ld    <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_vld   <= (r_state == S_DRAIN);
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_k <= '0;
                    end
                end
                S_ISSUE: begin
                    r_k <= w_last ? '0 : r_k + K_W'(1);
                    // Read data lags the issued address by one cycle.
                    if (!r_store && r_k != '0) begin
                        r_ld[int'(w_km1)*DATA_W +: DATA_W] <= sram.rdata;
                    end
                end
                S_DRAIN: begin
                    r_ld[(LANES-1)*DATA_W +: DATA_W] <= sram.rdata;
                end
                default: begin
                    r_k <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next  = r_state;
        w_csb   = 1'b1;
        w_web   = 1'b1;
        w_addr  = '0;
        w_wdata = '0;
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    // Vector wins over a coincident scalar request; the
                    // stalled pipeline re-presents the scalar one later.
                    w_next  = S_ISSUE;
                    w_stall = 1'b1;
                end else begin
                    w_csb   = scal_csb_i;
                    w_web   = scal_web_i;
                    w_addr  = scal_addr_i;
                    w_wdata = scal_wdata_i;
                end
            end
            S_ISSUE: begin
                w_csb  = 1'b0;
                w_web  = ~r_store;
                w_addr = w_lane_addr;
                if (r_store) begin
                    w_wdata = r_vdata[int'(r_k)*DATA_W +: DATA_W];
                end
                // Releasing the stall on the final store lane lets EX/MEM
                // advance exactly once; loads release it in DRAIN.
                w_stall = ~(r_store && w_last);
                if (w_last) begin
                    w_next = r_store ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Outputs are forced quiet for every cycle rst is held, even before
        // the state register has been cleared.
        if (rst) begin
            w_csb   = 1'b1;
            w_web   = 1'b1;
            w_addr  = '0;
            w_wdata = '0;
            w_stall = 1'b0;
        end
    end

    assign sram.csb      = w_csb;
    assign sram.web      = w_web;
    assign sram.addr     = w_addr;
    assign sram.wdata    = w_wdata;
    assign stall_o       = w_stall;
    assign busy_o        = ~rst && (r_state != S_IDLE);
    assign vload_data_o  = rst ? '0 : r_ld;
    assign vload_valid_o = ~rst && r_vld;

endmodule

// File: tb/tb_vmem_seq.sv
module tb_vmem_seq;
    localparam int LANES  = 8;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start_i;
    logic                    is_store_i;
    logic [31:0]             base_addr_i;
    logic [ADDR_W-1:0]       stride_i;
    logic [LANES*DATA_W-1:0] vdata_i;
    logic                    scal_csb_i;
    logic                    scal_web_i;
    logic [ADDR_W-1:0]       scal_addr_i;
    logic [DATA_W-1:0]       scal_wdata_i;
    logic                    stall_o;
    logic                    busy_o;
    logic [LANES*DATA_W-1:0] vload_data_o;
    logic                    vload_valid_o;

    vmem_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sram_bus ();

    vmem_seq #(.LANES(LANES), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .is_store_i   (is_store_i),
        .base_addr_i  (base_addr_i),
        .stride_i     (stride_i),
        .vdata_i      (vdata_i),
        .scal_csb_i   (scal_csb_i),
        .scal_web_i   (scal_web_i),
        .scal_addr_i  (scal_addr_i),
        .scal_wdata_i (scal_wdata_i),
        .sram         (sram_bus),
        .stall_o      (stall_o),
        .busy_o       (busy_o),
        .vload_data_o (vload_data_o),
        .vload_valid_o(vload_valid_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM model: a read returns its address + 0x1000 on the next cycle.
    always @(posedge clk) begin
        if (!sram_bus.csb && sram_bus.web)
            sram_bus.rdata <= 32'(sram_bus.addr) + 32'h1000;
    end

    typedef struct {
        int                cyc;
        logic              web;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_t;

    typedef struct {
        int                      cyc;
        logic [LANES*DATA_W-1:0] data;
    } ld_t;

    acc_t acc_q[$];
    ld_t  ld_q[$];

    int   errors = 0;
    int   checks = 0;
    int   adv    = 0;

    logic chk_ctl  = 1'b0;
    logic chk_rst  = 1'b0;
    logic adv_en   = 1'b0;
    logic adv_chk  = 1'b0;
    logic end_chk  = 1'b0;
    logic exp_stall = 1'b0;
    logic exp_busy  = 1'b0;

    acc_t e_acc;
    ld_t  e_ld;

    // Monitor: sole owner of the counters; pops the scoreboard whenever the
    // DUT presents an SRAM access or a load result.
    always @(negedge clk) begin
        if (!sram_bus.csb) begin
            checks++;
            if (acc_q.size() == 0) begin
                errors++;
                $display("FAIL sram_access: unexpected at cyc %0d web=%b addr=%h wdata=%h",
                         cyc, sram_bus.web, sram_bus.addr, sram_bus.wdata);
            end else begin
                e_acc = acc_q.pop_front();
                if (e_acc.cyc != cyc || e_acc.web != sram_bus.web ||
                    e_acc.addr != sram_bus.addr || e_acc.wdata != sram_bus.wdata) begin
                    errors++;
                    $display("FAIL sram_access: got cyc=%0d web=%b addr=%h wdata=%h required cyc=%0d web=%b addr=%h wdata=%h",
                             cyc, sram_bus.web, sram_bus.addr, sram_bus.wdata,
                             e_acc.cyc, e_acc.web, e_acc.addr, e_acc.wdata);
                end
            end
        end
        if (vload_valid_o) begin
            checks++;
            if (ld_q.size() == 0) begin
                errors++;
                $display("FAIL vload: unexpected valid at cyc %0d data=%h", cyc, vload_data_o);
            end else begin
                e_ld = ld_q.pop_front();
                if (e_ld.cyc != cyc || e_ld.data != vload_data_o) begin
                    errors++;
                    $display("FAIL vload: got cyc=%0d data=%h required cyc=%0d data=%h",
                             cyc, vload_data_o, e_ld.cyc, e_ld.data);
                end
            end
        end
        if (chk_ctl) begin
            checks++;
            if (stall_o !== exp_stall || busy_o !== exp_busy) begin
                errors++;
                $display("FAIL ctl: cyc %0d got stall=%b busy=%b required stall=%b busy=%b",
                         cyc, stall_o, busy_o, exp_stall, exp_busy);
            end
        end
        if (chk_rst) begin
            checks++;
            if (sram_bus.csb !== 1'b1 || sram_bus.web !== 1'b1 || sram_bus.addr !== '0 ||
                sram_bus.wdata !== '0 || stall_o !== 1'b0 || busy_o !== 1'b0 ||
                vload_valid_o !== 1'b0 || vload_data_o !== '0) begin
                errors++;
                $display("FAIL reset_vals: cyc %0d got csb=%b web=%b addr=%h wdata=%h stall=%b busy=%b vld=%b data=%h required csb=1 web=1 rest 0",
                         cyc, sram_bus.csb, sram_bus.web, sram_bus.addr, sram_bus.wdata,
                         stall_o, busy_o, vload_valid_o, vload_data_o);
            end
        end
        if (adv_en && start_i && !stall_o) adv++;
        if (adv_chk) begin
            checks++;
            if (adv != 2) begin
                errors++;
                $display("FAIL ex_mem_advance: got %0d required 2", adv);
            end
        end
        if (end_chk) begin
            checks++;
            if (acc_q.size() != 0 || ld_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d accesses %0d loads pending required 0 0",
                         acc_q.size(), ld_q.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scal_idle();
        scal_csb_i   = 1'b1;
        scal_web_i   = 1'b1;
        scal_addr_i  = '0;
        scal_wdata_i = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_stall = 1'b0;
            exp_busy  = 1'b0;
            tick();
        end
    endtask

    // One vector op held in EX/MEM until the stall releases it.
    task automatic vec_op(input bit st, input logic [ADDR_W-1:0] base,
                          input logic [ADDR_W-1:0] stride, input logic [DATA_W-1:0] dbase,
                          input bit noise);
        int                      t0;
        int                      n;
        logic [ADDR_W-1:0]       es;
        logic [ADDR_W-1:0]       a;
        logic [LANES*DATA_W-1:0] ld;
        acc_t                    x;
        ld_t                     y;
        t0 = cyc;
        n  = st ? 9 : 10;
`ifdef VMEM_SEQ_STRIDE_EN
        es = stride;
`else
        es = 16'd1;
`endif
        ld = '0;
        for (int k = 0; k < LANES; k++) begin
            a       = base + 16'(k) * es;
            x.cyc   = t0 + 1 + k;
            x.web   = ~st;
            x.addr  = a;
            x.wdata = st ? dbase + 32'(k) : 32'h0;
            acc_q.push_back(x);
            ld[k*DATA_W +: DATA_W] = 32'(a) + 32'h1000;
            vdata_i[k*DATA_W +: DATA_W] = dbase + 32'(k);
        end
        if (!st) begin
            y.cyc  = t0 + 10;
            y.data = ld;
            ld_q.push_back(y);
        end
        start_i     = 1'b1;
        is_store_i  = st;
        base_addr_i = {16'hABCD, base};
        stride_i    = stride;
        for (int c = 0; c < n; c++) begin
            if (noise) begin
                scal_csb_i   = 1'b0;
                scal_web_i   = 1'b0;
                scal_addr_i  = 16'h0020;
                scal_wdata_i = 32'hDEAD_BEEF;
            end else begin
                scal_idle();
            end
            exp_stall = (c < n - 1);
            exp_busy  = (c >= 1);
            tick();
        end
    endtask

    initial begin
        acc_t x;
        rst         = 1'b1;
        start_i     = 1'b0;
        is_store_i  = 1'b0;
        base_addr_i = '0;
        stride_i    = '0;
        vdata_i     = '0;
        scal_idle();

        // Power-on reset, then the first cycle after it.
        chk_rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk_ctl = 1'b1;
        idle(1);
        chk_rst = 1'b0;

        // Store: lanes 0xA0..0xA7 to 0x0100..
        vec_op(1'b1, 16'h0100, 16'h0001, 32'h0000_00A0, 1'b0);
        start_i = 1'b0;
        idle(2);

        // Load: lane k returns 0x1100+k; stride_i=1
        vec_op(1'b0, 16'h0100, 16'h0001, 32'h0, 1'b0);
        start_i = 1'b0;
        idle(3);

        // Wrap-around load with stride 3 (stride honoured only with the macro).
        vec_op(1'b0, 16'hFFFE, 16'h0003, 32'h0, 1'b0);
        start_i = 1'b0;
        idle(3);

        // Wrap-around store with stride 2.
        vec_op(1'b1, 16'hFFFC, 16'h0002, 32'h5500_0000, 1'b0);
        start_i = 1'b0;
        idle(2);

        // Scalar passthrough: write then read, same cycle on the SRAM pins.
        scal_csb_i = 1'b0; scal_web_i = 1'b0; scal_addr_i = 16'h0020; scal_wdata_i = 32'h1234_5678;
        x.cyc = cyc; x.web = 1'b0; x.addr = 16'h0020; x.wdata = 32'h1234_5678;
        acc_q.push_back(x);
        idle(1);
        scal_csb_i = 1'b0; scal_web_i = 1'b1; scal_addr_i = 16'h0030; scal_wdata_i = 32'h0;
        x.cyc = cyc; x.web = 1'b1; x.addr = 16'h0030; x.wdata = 32'h0;
        acc_q.push_back(x);
        idle(1);
        scal_idle();
        idle(1);

        // Scalar request alongside start_i and throughout ISSUE: must not leak.
        vec_op(1'b1, 16'h0200, 16'h0001, 32'h0000_00C0, 1'b1);
        start_i = 1'b0;
        scal_idle();
        idle(2);

        // Back-to-back store then load; EX/MEM must advance exactly twice.
        adv_en = 1'b1;
        vec_op(1'b1, 16'h0300, 16'h0001, 32'h0000_00E0, 1'b0);
        vec_op(1'b0, 16'h0300, 16'h0001, 32'h0, 1'b0);
        start_i = 1'b0;
        adv_en  = 1'b0;
        adv_chk = 1'b1;
        idle(1);
        adv_chk = 1'b0;
        idle(2);

        // Reset mid-load at k = 3: only lanes 0..2 are ever issued.
        begin
            int t0;
            t0 = cyc;
            for (int k = 0; k < 3; k++) begin
                x.cyc = t0 + 1 + k; x.web = 1'b1; x.addr = 16'h0400 + 16'(k); x.wdata = 32'h0;
                acc_q.push_back(x);
            end
            start_i     = 1'b1;
            is_store_i  = 1'b0;
            base_addr_i = 32'h0000_0400;
            stride_i    = 16'h0001;
            for (int c = 0; c < 4; c++) begin
                exp_stall = 1'b1;
                exp_busy  = (c >= 1);
                tick();
            end
            rst     = 1'b1;
            start_i = 1'b0;
            chk_rst = 1'b1;
            idle(2);
            rst = 1'b0;
            idle(1);
            chk_rst = 1'b0;
            idle(12);
        end

        end_chk = 1'b1;
        idle(1);
        end_chk = 1'b0;
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
